// File: rtl/layer_sched.sv
// -----------------------------------------------------------------------------
// layer_sched
// Layer sequencer for the accelerator. Walks a programmable table of layer
// descriptors and launches one compute engine (conv, pool or fc) per layer.
// It holds that engine's enable until the engine reports done, and a watchdog
// bounds each layer. It also owns the single DRAM port and routes the active
// engine's request signals onto it.
//
// Ports:
//   clk, srstn            clock, asynchronous active-low reset
//   start                 one-cycle pulse that begins the table walk
//   cfg_we/idx/type       descriptor table write port (ignored while busy)
//   en_eng / done_eng     per-engine enable (one-hot or zero) / done flags
//   eng_*                 per-engine DRAM request buses, slice k = engine k
//   dram_*                DRAM request port driven by the active engine
//   busy, done, err       walk in progress, completion pulse, sticky watchdog
//   cur_layer             index of the layer in progress
// -----------------------------------------------------------------------------
module layer_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int MAX_LAYERS = 8,
    parameter int IDX_WIDTH  = 3,
    parameter int TIMEOUT    = 2**20
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    start,
    input  logic                    cfg_we,
    input  logic [IDX_WIDTH-1:0]    cfg_idx,
    input  logic [1:0]              cfg_type,
    output logic [2:0]              en_eng,
    input  logic [2:0]              done_eng,
    input  logic [3*ADDR_WIDTH-1:0] eng_addr_rd,
    input  logic [3*ADDR_WIDTH-1:0] eng_addr_wr,
    input  logic [3*DATA_WIDTH-1:0] eng_wdata,
    input  logic [2:0]              eng_en_rd,
    input  logic [2:0]              eng_en_wr,
    output logic [ADDR_WIDTH-1:0]   dram_addr_rd,
    output logic [ADDR_WIDTH-1:0]   dram_addr_wr,
    output logic [DATA_WIDTH-1:0]   dram_wdata,
    output logic                    dram_en_rd,
    output logic                    dram_en_wr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [IDX_WIDTH-1:0]    cur_layer
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [1:0]     T_END    = 2'd3;
    localparam logic [CW-1:0]  WD_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MAX_LAYERS - 1);

    state_t                 state_q;
    logic [1:0]             tbl_q [MAX_LAYERS];
    logic [2:0]             en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [IDX_WIDTH-1:0]   curLayer_q;
    logic [CW-1:0]          wdCnt_q;

    logic [IDX_WIDTH-1:0]   nxtIdx_d;
    logic [1:0]             nxtType_d;
    logic                   activeDone_d;

    function automatic logic [2:0] onehot(input logic [1:0] t);
        case (t)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // The last table slot is treated as followed by END so the walk never
    // reads past the table and cur_layer never wraps.
    always_comb begin
        nxtIdx_d  = curLayer_q + 1'b1;
        nxtType_d = (curLayer_q == LAST_IDX) ? T_END : tbl_q[nxtIdx_d];
    end

    // Masking with the registered enable means only the active engine's done
    // flag can end a layer.
    assign activeDone_d = |(done_eng & en_q);

    // Descriptor table; frozen while a walk is in progress.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tbl_q[i] <= T_END;
            end
        end else if (cfg_we && !busy_q) begin
            tbl_q[cfg_idx] <= cfg_type;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= IDLE;
            en_q       <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            curLayer_q <= '0;
            wdCnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        wdCnt_q <= '0;
                        if (tbl_q[0] != T_END) begin
                            curLayer_q <= '0;
                            en_q       <= onehot(tbl_q[0]);
                            state_q    <= RUN;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                RUN: begin
                    // A done arriving on the final watchdog cycle still wins.
                    if (activeDone_d) begin
                        en_q    <= 3'b000;
                        wdCnt_q <= '0;
                        state_q <= GAP;
                    end else if (wdCnt_q == WD_LAST) begin
                        en_q    <= 3'b000;
                        err_q   <= 1'b1;
                        wdCnt_q <= '0;
                        state_q <= FIN;
                    end else begin
                        wdCnt_q <= wdCnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (nxtType_d == T_END) begin
                        state_q <= FIN;
                    end else begin
                        curLayer_q <= nxtIdx_d;
                        en_q       <= onehot(nxtType_d);
                        state_q    <= RUN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // DRAM port follows the registered enable, so nothing leaks in GAP/IDLE.
    always_comb begin
        dram_addr_rd = '0;
        dram_addr_wr = '0;
        dram_wdata   = '0;
        dram_en_rd   = 1'b0;
        dram_en_wr   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (en_q == 3'(1 << k)) begin
                dram_addr_rd = eng_addr_rd[k*ADDR_WIDTH +: ADDR_WIDTH];
                dram_addr_wr = eng_addr_wr[k*ADDR_WIDTH +: ADDR_WIDTH];
                dram_wdata   = eng_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                dram_en_rd   = eng_en_rd[k];
                dram_en_wr   = eng_en_wr[k];
            end
        end
    end

    assign en_eng    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cur_layer = curLayer_q;

endmodule

// File: tb/tb_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_layer_sched
// Self-checking bench for layer_sched. A behavioural model turns the layer
// table plus per-layer engine latencies into the expected cycle-by-cycle
// trace of the sequencer's outputs; the bench plays the engines from that
// trace and checks every cycle, including the DRAM port routing.
// -----------------------------------------------------------------------------
module tb_layer_sched;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk;
    logic            srstn;
    logic            start;
    logic            cfg_we;
    logic [2:0]      cfg_idx;
    logic [1:0]      cfg_type;
    logic [2:0]      en_eng;
    logic [2:0]      done_eng;
    logic [3*AW-1:0] eng_addr_rd;
    logic [3*AW-1:0] eng_addr_wr;
    logic [3*DW-1:0] eng_wdata;
    logic [2:0]      eng_en_rd;
    logic [2:0]      eng_en_wr;
    logic [AW-1:0]   dram_addr_rd;
    logic [AW-1:0]   dram_addr_wr;
    logic [DW-1:0]   dram_wdata;
    logic            dram_en_rd;
    logic            dram_en_wr;
    logic            busy;
    logic            done;
    logic            err;
    logic [2:0]      cur_layer;

    // One expected output cycle; drv is the done pattern the active engine
    // presents during that cycle.
    typedef struct packed {
        logic [2:0] en;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] cur;
        logic [2:0] drv;
    } rec_t;

    rec_t trace[$];
    int   tbl[8];
    int   dly[8];
    logic modelErr;
    int   modelCur;
    int   assertCount;
    int   failCount;

    layer_sched #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_LAYERS(8),
        .IDX_WIDTH (3),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .srstn       (srstn),
        .start       (start),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_type    (cfg_type),
        .en_eng      (en_eng),
        .done_eng    (done_eng),
        .eng_addr_rd (eng_addr_rd),
        .eng_addr_wr (eng_addr_wr),
        .eng_wdata   (eng_wdata),
        .eng_en_rd   (eng_en_rd),
        .eng_en_wr   (eng_en_wr),
        .dram_addr_rd(dram_addr_rd),
        .dram_addr_wr(dram_addr_wr),
        .dram_wdata  (dram_wdata),
        .dram_en_rd  (dram_en_rd),
        .dram_en_wr  (dram_en_wr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_layer   (cur_layer)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic rec_t mk(input logic [2:0] en, input logic b, input logic d,
                                input logic e, input int cur, input logic [2:0] drv);
        rec_t r;
        r.en   = en;
        r.busy = b;
        r.done = d;
        r.err  = e;
        r.cur  = 3'(cur);
        r.drv  = drv;
        return r;
    endfunction

    // Compares one observation with its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all sequencer outputs plus the DRAM port against one record.
    task automatic checkAll(input rec_t r);
        logic [AW-1:0] ear;
        logic [AW-1:0] eaw;
        logic [DW-1:0] ewd;
        logic          erd;
        logic          ewr;
        ear = '0; eaw = '0; ewd = '0; erd = 1'b0; ewr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (r.en == 3'(1 << k)) begin
                ear = eng_addr_rd[k*AW +: AW];
                eaw = eng_addr_wr[k*AW +: AW];
                ewd = eng_wdata[k*DW +: DW];
                erd = eng_en_rd[k];
                ewr = eng_en_wr[k];
            end
        end
        checkOutput("en_eng",       32'(en_eng),       32'(r.en));
        checkOutput("busy",         32'(busy),         32'(r.busy));
        checkOutput("done",         32'(done),         32'(r.done));
        checkOutput("err",          32'(err),          32'(r.err));
        checkOutput("cur_layer",    32'(cur_layer),    32'(r.cur));
        checkOutput("dram_addr_rd", 32'(dram_addr_rd), 32'(ear));
        checkOutput("dram_addr_wr", 32'(dram_addr_wr), 32'(eaw));
        checkOutput("dram_wdata",   dram_wdata,        ewd);
        checkOutput("dram_en_rd",   32'(dram_en_rd),   32'(erd));
        checkOutput("dram_en_wr",   32'(dram_en_wr),   32'(ewr));
    endtask

    // Drives engine behaviour for one cycle: the active engine's done comes
    // from the record, other done bits are noise, DRAM requests are random,
    // and while busy stray starts and table writes are thrown in.
    task automatic applyStimulus(input rec_t r);
        if (r.en != 3'b000) done_eng = r.drv | (3'($urandom) & ~r.en);
        else                done_eng = 3'($urandom);
        for (int k = 0; k < 3; k++) begin
            eng_addr_rd[k*AW +: AW] = AW'($urandom);
            eng_addr_wr[k*AW +: AW] = AW'($urandom);
            eng_wdata[k*DW +: DW]   = $urandom;
        end
        eng_en_rd = 3'($urandom);
        eng_en_wr = 3'($urandom);
        if (r.busy) begin
            start    = ($urandom_range(0, 3) == 0);
            cfg_we   = ($urandom_range(0, 1) == 0);
            cfg_idx  = 3'($urandom);
            cfg_type = 2'($urandom);
        end else begin
            start  = 1'b0;
            cfg_we = 1'b0;
        end
    endtask

    // Builds the expected trace of one walk from the table and latencies.
    task automatic buildTrace();
        int n;
        logic [2:0] oh;
        int runLen;
        trace.delete();
        n = 0;
        while (n < 8 && tbl[n] != 3) n++;
        if (n == 0) begin
            trace.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, modelCur, 3'b000));
            trace.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, modelCur, 3'b000));
            modelErr = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            oh = 3'(1 << tbl[i]);
            runLen = (dly[i] <= TO) ? dly[i] : TO;
            for (int j = 1; j <= runLen; j++) begin
                trace.push_back(mk(oh, 1'b1, 1'b0, 1'b0, i, (j == dly[i]) ? oh : 3'b000));
            end
            if (dly[i] > TO) begin
                trace.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, i, 3'b000));
                trace.push_back(mk(3'b000, 1'b0, 1'b1, 1'b1, i, 3'b000));
                modelErr = 1'b1;
                modelCur = i;
                return;
            end
            trace.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, i, 3'b000));
            if (i == n - 1) begin
                trace.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, i, 3'b000));
                trace.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, i, 3'b000));
            end
        end
        modelErr = 1'b0;
        modelCur = n - 1;
    endtask

    // Loads the model table into the DUT while idle.
    task automatic writeTable();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_idx  = 3'(i);
            cfg_type = 2'(tbl[i]);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulses start and checks every cycle of the walk plus two idle cycles.
    task automatic runWalk();
        rec_t idleRec;
        buildTrace();
        @(negedge clk);
        start  = 1'b1;
        cfg_we = 1'b0;
        foreach (trace[t]) begin
            @(negedge clk);
            start = 1'b0;
            checkAll(trace[t]);
            applyStimulus(trace[t]);
        end
        idleRec = mk(3'b000, 1'b0, 1'b0, modelErr, modelCur, 3'b000);
        repeat (2) begin
            @(negedge clk);
            checkAll(idleRec);
            applyStimulus(idleRec);
        end
    endtask

    // Directed scenarios first, then randomized tables, then mid-run reset.
    initial begin
        rec_t rstRec;
        assertCount = 0;
        failCount   = 0;
        modelErr    = 1'b0;
        modelCur    = 0;
        srstn       = 1'b0;
        start       = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_type    = '0;
        done_eng    = '0;
        eng_addr_rd = '0;
        eng_addr_wr = '0;
        eng_wdata   = '0;
        eng_en_rd   = '0;
        eng_en_wr   = '0;
        for (int i = 0; i < 8; i++) tbl[i] = 3;

        rstRec = mk(3'b000, 1'b0, 1'b0, 1'b0, 0, 3'b000);
        repeat (2) @(negedge clk);
        applyStimulus(rstRec);
        @(negedge clk);
        checkAll(rstRec);
        srstn = 1'b1;
        $display("[TB] reset released");

        // conv, pool, fc with 10-cycle engines
        tbl = '{0, 1, 2, 3, 3, 3, 3, 3};
        for (int i = 0; i < 8; i++) dly[i] = 10;
        writeTable();
        runWalk();

        // empty table
        tbl = '{3, 3, 3, 3, 3, 3, 3, 3};
        writeTable();
        runWalk();

        // full table of conv layers, walk must stop after slot 7
        for (int i = 0; i < 8; i++) begin
            tbl[i] = 0;
            dly[i] = $urandom_range(1, 5);
        end
        writeTable();
        runWalk();

        // watchdog expiry, then done on the last allowed cycle, then one past
        tbl = '{0, 3, 3, 3, 3, 3, 3, 3};
        writeTable();
        dly[0] = 1000;
        runWalk();
        dly[0] = TO;
        runWalk();
        dly[0] = TO + 1;
        runWalk();
        dly[0] = 1;
        runWalk();

        // randomized tables and engine latencies
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 8; i++) begin
                tbl[i] = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
                dly[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(TO + 1, TO + 4)
                                                      : $urandom_range(1, 12);
            end
            writeTable();
            runWalk();
        end
        $display("[TB] random walks complete");

        // asynchronous reset in the middle of a pool layer
        tbl = '{1, 2, 0, 3, 3, 3, 3, 3};
        writeTable();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        done_eng  = 3'b000;
        eng_en_rd = 3'b111;
        eng_en_wr = 3'b111;
        repeat (3) @(negedge clk);
        checkOutput("midrun_en", 32'(en_eng), 32'(3'b010));
        #2;
        srstn = 1'b0;
        #1;
        checkAll(rstRec);
        @(negedge clk);
        srstn = 1'b1;
        for (int i = 0; i < 8; i++) tbl[i] = 3;
        modelErr = 1'b0;
        modelCur = 0;
        runWalk();

        // only slot 0 rewritten; slot 1 must still be END after the reset
        tbl[0] = 2;
        dly[0] = 3;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = 3'd0;
        cfg_type = 2'd2;
        @(negedge clk);
        cfg_we = 1'b0;
        runWalk();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Layer sequencer for the accelerator. Walks a programmable table of layer descriptors and launches one compute engine per layer: conv, pool or fc.
- Holds the selected engine's enable until that engine reports done, with a watchdog on each layer.
- Owns the single DRAM port and muxes the active engine's request signals onto it. DRAM read data is broadcast to all engines.

Parameters:
- DATA_WIDTH, 32, DRAM data width.
- ADDR_WIDTH, 18, DRAM address width.
- MAX_LAYERS, 8, number of descriptor table entries.
- IDX_WIDTH, 3, width of a table index; equals clog2(MAX_LAYERS).
- TIMEOUT, 2^20, maximum number of RUN cycles per layer before a watchdog error.

Ports:
- clk  in  1  clock.
- srstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins the table walk.
- cfg_we  in  1  descriptor write strobe.
- cfg_idx  in  IDX_WIDTH  descriptor index.
- cfg_type  in  2  layer type: 0 conv, 1 pool, 2 fc, 3 END.
- en_eng  out  3  engine enables, one-hot or zero; bit0 conv, bit1 pool, bit2 fc.
- done_eng  in  3  engine done flags, same bit order.
- eng_addr_rd  in  3*ADDR_WIDTH  per-engine read address; slice k belongs to engine k.
- eng_addr_wr  in  3*ADDR_WIDTH  per-engine write address.
- eng_wdata  in  3*DATA_WIDTH  per-engine write data.
- eng_en_rd  in  3  per-engine read request.
- eng_en_wr  in  3  per-engine write request.
- dram_addr_rd  out  ADDR_WIDTH  muxed read address.
- dram_addr_wr  out  ADDR_WIDTH  muxed write address.
- dram_wdata  out  DATA_WIDTH  muxed write data.
- dram_en_rd  out  1  muxed read enable.
- dram_en_wr  out  1  muxed write enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky watchdog error.
- cur_layer  out  IDX_WIDTH  index of the layer in progress.

Behaviour:
- Reset values:
  - en_eng=0, busy=0, done=0, err=0, cur_layer=0, state=IDLE.
  - All table entries reset to END (3).
- Table:
  - cfg_we writes cfg_type into entry cfg_idx on the clock edge.
  - cfg_we is ignored while busy=1.
- States: IDLE, RUN, GAP, FIN.
- IDLE:
  - start=1 and entry0≠END: cur_layer←0, en_eng←onehot(entry0), busy←1, next state RUN. The enable is visible on the cycle after start.
  - start=1 and entry0=END: busy←1, next state FIN. No engine is ever enabled.
  - start while busy=1 is ignored.
- RUN:
  - The enable is held, and the watchdog counter increments every RUN cycle.
  - Only done_eng[active] is sampled. Done flags from non-active engines are ignored.
  - done_eng[active]=1: en_eng←0, counter←0, next state GAP.
  - Counter reaches TIMEOUT-1 without done: en_eng←0, err←1, next state FIN. The remaining layers are skipped.
- GAP:
  - Lasts exactly 1 cycle with all enables low, so each engine sees enable drop and returns to its idle state.
  - If cur_layer=MAX_LAYERS-1 or entry[cur_layer+1]=END: next state FIN.
  - Otherwise: cur_layer←cur_layer+1, en_eng←onehot(next type), next state RUN.
- FIN:
  - done=1 for one cycle, busy←0, next state IDLE.
  - err stays high until the next accepted start, which clears it.
- DRAM mux:
  - Combinational on the registered en_eng.
  - With active engine k, all five DRAM outputs carry slice k.
  - With en_eng=0, dram_en_rd=0, dram_en_wr=0, and addresses and data are driven to 0.
  - No DRAM request can leak during GAP or IDLE.
- Widths:
  - The watchdog counter is clog2(TIMEOUT)+1 bits.
  - cur_layer never wraps; the walk stops at MAX_LAYERS-1.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous) and the table is cleared to END.

Test Plan:
- Table {conv, pool, fc, END}, start; each engine pulses done 10 cycles after its enable → en_eng = 001, 010, 100 with one zero cycle between each; cur_layer goes 0→1→2; done pulses exactly once; err=0.
- Entry0=END, start → done pulses 2 cycles after start; en_eng stays 0 throughout; busy is high for those cycles only.
- All 8 entries conv → 8 conv launches; after layer 7 the block enters FIN without reading past the table; cur_layer=7 at done.
- TIMEOUT set to 16, conv never asserts done → en_eng drops after 16 RUN cycles; err=1; done pulses. A following start clears err.
- During a conv layer, pool drives eng_en_wr=1 and addr 0x3FFFF and fc asserts done_eng → dram_en_wr and dram_addr_wr follow the conv slice only, and the sequencer stays in RUN. During GAP, dram_en_rd=dram_en_wr=0.
- cfg_we while busy changes no entry. srstn low mid-RUN → en_eng=0 and busy=0 immediately, and every table entry reads back as END afterwards.
